fc_argmax: RTL and testbench
============================

Name: fc_argmax

Overview:
- Downstream classifier stage for fc_12.
- Consumes the serial stream of signed 16-bit class scores (one per fc_12 ovalid pulse), one frame of NUM_CLASS scores per image.
- Produces the winning class index, its score, and the top-1/top-2 margin.
- Final stage of the BNN inference pipeline; results go to the host/readout logic.

Parameters:
- NUM_CLASS, 10, number of scores per frame (2..16)
- IDX_W, 4, width of class index; must satisfy 2^IDX_W >= NUM_CLASS
- SCORE_W, 16, score width, signed two's complement

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  reset, synchronous, active-low
- start  input  1  single-cycle pulse; abort any partial frame and begin a new one
- ivalid  input  1  score valid; driven from fc_12 ovalid
- din  input  SCORE_W  signed score; driven from fc_12 dout
- busy  output  1  high while a frame is partially received
- ovalid  output  1  one-cycle pulse, result valid
- class_id  output  IDX_W  index of the maximum score
- max_score  output  SCORE_W  signed maximum score
- margin  output  SCORE_W  unsigned; max minus second-best, saturated

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state IDLE; cnt=0; busy=0; ovalid=0
  - class_id=0; max_score=0; margin=0
  - internal best/second registers cleared
- States:
  - IDLE -> ACC on the first accepted score.
  - ACC -> DONE on acceptance of score NUM_CLASS-1.
  - DONE -> IDLE after exactly one cycle; ovalid=1 only in DONE.
- Score acceptance and index counting:
  - A score is accepted on any cycle with ivalid=1.
  - Scores are indexed 0..NUM_CLASS-1 in arrival order via cnt; cnt wraps to 0 after the last score.
- First score of a frame:
  - best=din, best_idx=0.
  - second = most negative value (-2^(SCORE_W-1)).
- Later scores:
  - If din > best (signed, strict): second=best, best=din, best_idx=cnt.
  - Else if din > second: second=din.
  - Ties keep the lower index.
- Latency: ovalid asserts the cycle after the last score is accepted.
  - class_id, max_score and margin update in that same cycle and hold until the next ovalid.
- Margin computation and saturation:
  - Computed at SCORE_W+1 bits as best - second.
  - Values above 2^SCORE_W-1 saturate to all-ones.
  - NUM_CLASS=... the margin is always computed against the second-best score.
- busy: 1 in ACC, 0 in IDLE and DONE.
- start handling:
  - start=1 clears cnt, best and second and returns to IDLE; published outputs are not cleared.
  - If start and ivalid are both high in the same cycle, start applies first and din is accepted as index 0 of the new frame.
- ivalid during DONE: accepted as index 0 of the next frame (back-to-back frames, no bubble required).
- Reset mid-frame: partial frame discarded; no ovalid.
- Arithmetic: all comparisons are signed SCORE_W-bit; no overflow is possible in the comparisons.

Optional Feature:
- FC_ARGMAX_SCORE_BUF_EN
- Defined:
  - Adds a NUM_CLASS x SCORE_W register buffer written at index cnt on each accepted score.
  - Adds a read port: rd_addr input IDX_W, rd_data output SCORE_W.
  - rd_data is registered (1-cycle read latency); reset value 0.
  - The buffer is double-banked and swaps on ovalid, so reads always return the last completed frame.
  - Out-of-range rd_addr returns 0.
- Undefined: no buffer, no rd_addr/rd_data ports; behaviour otherwise identical.

Decomposition:
- Shared package bnn_pkg holds:
  - SCORE_W, NUM_CLASS, IDX_W defaults
  - the state enum (IDLE, ACC, DONE)
  - the SCORE_MIN constant
- One natural sub-module: fc_argmax_cmp, a combinational best/second update from (best, second, best_idx, din, cnt).
- The buffer is instantiated inside fc_argmax under the macro.

Test Plan:
- Ordered frame: scores 0,10,20,...,90 on consecutive cycles -> ovalid 1 cycle after the 10th score; class_id=9, max_score=90, margin=10.
- Negative and tie frame: all scores -5 except index 3 = -1 and index 7 = -1 -> class_id=3, max_score=-1, margin=0.
- Saturation: index 0 = 32767, all others -32768 -> class_id=0, margin=16'hFFFF.
- Start mid-frame: 4 scores, then start together with ivalid (din=50), then 9 more scores all <50 -> exactly one ovalid; class_id=0, max_score=50.
- Back-to-back frames with gapped ivalid: frame A winner at index 2, frame B (ivalid during A's DONE cycle) winner at index 8 -> two ovalid pulses with class_id 2 then 8; busy low only in IDLE/DONE.
- Reset mid-frame: rstn low for 1 cycle after 5 scores -> all outputs 0, no ovalid; the next full frame is reported correctly.
- Macro enabled: after frame 0..9 = 9..0, rd_addr=4 -> rd_data=5 one cycle later; the value holds while the next frame streams in.

Source files
------------

// File: rtl/bnn_pkg.sv
//==============================================================================
// Module      : bnn_pkg
// Description : Shared defaults, argmax state encoding and score constants for
//               the BNN classifier back end.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bnn_pkg;

    localparam int SCORE_W   = 16;
    localparam int NUM_CLASS = 10;
    localparam int IDX_W     = 4;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fc_argmax_cmp.sv
//==============================================================================
// Module      : fc_argmax_cmp
// Description : Combinational top-2 update for one incoming score, plus the
//               saturated best-minus-second margin of the updated pair.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fc_argmax_cmp #(
    parameter int SCORE_W = bnn_pkg::SCORE_W,
    parameter int IDX_W   = bnn_pkg::IDX_W
) (
    input  logic signed [SCORE_W-1:0] i_best,
    input  logic signed [SCORE_W-1:0] i_second,
    input  logic        [IDX_W-1:0]   i_best_idx,
    input  logic signed [SCORE_W-1:0] i_din,
    input  logic        [IDX_W-1:0]   i_cnt,
    output logic signed [SCORE_W-1:0] o_best,
    output logic signed [SCORE_W-1:0] o_second,
    output logic        [IDX_W-1:0]   o_best_idx,
    output logic        [SCORE_W-1:0] o_margin
);

    localparam logic signed [SCORE_W-1:0] c_score_min = {1'b1, {(SCORE_W-1){1'b0}}};

    logic [SCORE_W:0] w_diff;

    // Strict compares keep the earliest index on ties.
    always_comb begin
        o_best     = i_best;
        o_second   = i_second;
        o_best_idx = i_best_idx;
        if (i_cnt == '0) begin
            o_best     = i_din;
            o_second   = c_score_min;
            o_best_idx = '0;
        end else if (i_din > i_best) begin
            o_second   = i_best;
            o_best     = i_din;
            o_best_idx = i_cnt;
        end else if (i_din > i_second) begin
            o_second   = i_din;
        end
    end

    assign w_diff   = {o_best[SCORE_W-1], o_best} - {o_second[SCORE_W-1], o_second};
    assign o_margin = w_diff[SCORE_W] ? {SCORE_W{1'b1}} : w_diff[SCORE_W-1:0];

endmodule

`default_nettype wire

// File: rtl/fc_argmax.sv
//==============================================================================
// Module      : fc_argmax
// Description : Streaming argmax over one frame of NUM_CLASS signed scores;
//               publishes winner index, max score and top-1/top-2 margin.
//               Optional FC_ARGMAX_SCORE_BUF_EN adds a double-banked score
//               buffer with a registered read port (rd_addr / rd_data).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fc_argmax #(
    parameter int NUM_CLASS = bnn_pkg::NUM_CLASS,
    parameter int IDX_W     = bnn_pkg::IDX_W,
    parameter int SCORE_W   = bnn_pkg::SCORE_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      ivalid,
    input  logic signed [SCORE_W-1:0] din,
    output logic                      busy,
    output logic                      ovalid,
    output logic        [IDX_W-1:0]   class_id,
    output logic signed [SCORE_W-1:0] max_score,
    output logic        [SCORE_W-1:0] margin
`ifdef FC_ARGMAX_SCORE_BUF_EN
    ,
    input  logic        [IDX_W-1:0]   rd_addr,
    output logic signed [SCORE_W-1:0] rd_data
`endif
);

    import bnn_pkg::*;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CLASS - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [IDX_W-1:0]   r_cnt;
    logic signed [SCORE_W-1:0] r_best;
    logic signed [SCORE_W-1:0] r_second;
    logic        [IDX_W-1:0]   r_best_idx;
    logic        [IDX_W-1:0]   r_class_id;
    logic signed [SCORE_W-1:0] r_max_score;
    logic        [SCORE_W-1:0] r_margin;

    logic        [IDX_W-1:0]   w_cnt_eff;
    logic                      w_last;
    logic signed [SCORE_W-1:0] w_best_nxt;
    logic signed [SCORE_W-1:0] w_second_nxt;
    logic        [IDX_W-1:0]   w_best_idx_nxt;
    logic        [SCORE_W-1:0] w_margin_nxt;

    // start restarts indexing so a same-cycle score lands at index 0.
    assign w_cnt_eff = start ? '0 : r_cnt;
    assign w_last    = ivalid && (w_cnt_eff == c_last_idx);

    fc_argmax_cmp #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_cmp (
        .i_best     (r_best),
        .i_second   (r_second),
        .i_best_idx (r_best_idx),
        .i_din      (din),
        .i_cnt      (w_cnt_eff),
        .o_best     (w_best_nxt),
        .o_second   (w_second_nxt),
        .o_best_idx (w_best_idx_nxt),
        .o_margin   (w_margin_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ivalid) begin
            w_state_nxt = w_last ? DONE : ACC;
        end else if (start || (r_state == DONE)) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        busy   = (r_state == ACC);
        ovalid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_best      <= '0;
            r_second    <= '0;
            r_best_idx  <= '0;
            r_class_id  <= '0;
            r_max_score <= '0;
            r_margin    <= '0;
        end else if (ivalid) begin
            r_best     <= w_best_nxt;
            r_second   <= w_second_nxt;
            r_best_idx <= w_best_idx_nxt;
            r_cnt      <= w_last ? '0 : w_cnt_eff + 1'b1;
            if (w_last) begin
                r_class_id  <= w_best_idx_nxt;
                r_max_score <= w_best_nxt;
                r_margin    <= w_margin_nxt;
            end
        end else if (start) begin
            r_cnt      <= '0;
            r_best     <= '0;
            r_second   <= '0;
            r_best_idx <= '0;
        end
    end

    assign class_id  = r_class_id;
    assign max_score = r_max_score;
    assign margin    = r_margin;

`ifdef FC_ARGMAX_SCORE_BUF_EN
    localparam logic [IDX_W:0] c_num_class = (IDX_W+1)'(NUM_CLASS);

    logic signed [SCORE_W-1:0] r_buf [2][NUM_CLASS];
    logic                      r_wbank;
    logic signed [SCORE_W-1:0] r_rd_data;

    // The write bank flips as the last score lands, so the DONE cycle and
    // any back-to-back score already target the other bank.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wbank   <= 1'b0;
            r_rd_data <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_CLASS; i++) begin
                    r_buf[b][i] <= '0;
                end
            end
        end else begin
            if (ivalid) begin
                r_buf[r_wbank][w_cnt_eff] <= din;
            end
            if (w_last) begin
                r_wbank <= ~r_wbank;
            end
            if ({1'b0, rd_addr} < c_num_class) begin
                r_rd_data <= r_buf[~r_wbank][rd_addr];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_argmax.sv
//==============================================================================
// Module      : tb_fc_argmax
// Description : Self-checking bench for fc_argmax: directed frames with literal
//               expectations plus randomized traffic against a frame model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fc_argmax;

    localparam int N  = 10;
    localparam int IW = 4;
    localparam int SW = 16;

    logic                 clk    = 1'b0;
    logic                 rstn   = 1'b0;
    logic                 start  = 1'b0;
    logic                 ivalid = 1'b0;
    logic signed [SW-1:0] din    = '0;
    logic                 busy;
    logic                 ovalid;
    logic        [IW-1:0] class_id;
    logic signed [SW-1:0] max_score;
    logic        [SW-1:0] margin;
`ifdef FC_ARGMAX_SCORE_BUF_EN
    logic        [IW-1:0] rd_addr = '0;
    logic signed [SW-1:0] rd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_ov     = 0;

    always #5 clk = ~clk;

    fc_argmax #(
        .NUM_CLASS (N),
        .IDX_W     (IW),
        .SCORE_W   (SW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .ivalid    (ivalid),
        .din       (din),
        .busy      (busy),
        .ovalid    (ovalid),
        .class_id  (class_id),
        .max_score (max_score),
        .margin    (margin)
`ifdef FC_ARGMAX_SCORE_BUF_EN
        ,
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`endif
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: collect scores, then take the argmax and the best of the rest.
    int q[$];
    int m_cls = 0, m_max = 0, m_margin = 0, m_rd = 0;
    bit m_ovalid = 0, m_busy = 0;
    int last_frame[N];

    always @(posedge clk) begin
        bit s_rstn, s_start, s_iv;
        int s_din, s_addr, bi, sec;
        s_rstn  = rstn;
        s_start = start;
        s_iv    = ivalid;
        s_din   = din;
`ifdef FC_ARGMAX_SCORE_BUF_EN
        s_addr  = int'(rd_addr);
`else
        s_addr  = 0;
`endif
        if (!s_rstn) begin
            q.delete();
            m_ovalid = 0; m_busy = 0; m_cls = 0; m_max = 0; m_margin = 0; m_rd = 0;
            for (int i = 0; i < N; i++) last_frame[i] = 0;
        end else begin
            m_rd = (s_addr < N) ? last_frame[s_addr] : 0;
            m_ovalid = 0;
            if (s_start) q.delete();
            if (s_iv) q.push_back(s_din);
            if (q.size() == N) begin
                bi = 0;
                for (int i = 1; i < N; i++) if (q[i] > q[bi]) bi = i;
                sec = -(1 << (SW - 1));
                for (int i = 0; i < N; i++) if (i != bi && q[i] > sec) sec = q[i];
                m_cls    = bi;
                m_max    = q[bi];
                m_margin = q[bi] - sec;
                if (m_margin > (1 << SW) - 1) m_margin = (1 << SW) - 1;
                for (int i = 0; i < N; i++) last_frame[i] = q[i];
                q.delete();
                m_ovalid = 1;
            end
            m_busy = (q.size() != 0);
        end
        #1;
        chk("ovalid", ovalid, m_ovalid);
        chk("busy", busy, m_busy);
        chk("class_id", class_id, m_cls);
        chk("max_score", max_score, m_max);
        chk("margin", margin, m_margin);
`ifdef FC_ARGMAX_SCORE_BUF_EN
        chk("rd_data", rd_data, m_rd);
`endif
        if (ovalid === 1'b1) n_ov++;
    end

    task automatic cyc(input bit v, input int d, input bit st = 1'b0);
        ivalid = v;
        din    = d[SW-1:0];
        start  = st;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0);
    endtask

    initial begin
        int ov0, r, d;

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("rst_class_id", class_id, 0);
        chk("rst_max_score", max_score, 0);
        chk("rst_margin", margin, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_busy", busy, 0);

        // Ordered frame
        for (int i = 0; i < N; i++) cyc(1'b1, i * 10);
        chk("ord_ovalid", ovalid, 1);
        chk("ord_class", class_id, 9);
        chk("ord_max", max_score, 90);
        chk("ord_margin", margin, 10);
        idle(2);
        chk("ord_hold_class", class_id, 9);

        // Negative frame with a tie at the top
        for (int i = 0; i < N; i++) cyc(1'b1, (i == 3 || i == 7) ? -1 : -5);
        chk("tie_class", class_id, 3);
        chk("tie_max", max_score, -1);
        chk("tie_margin", margin, 0);
        idle(1);

        // Saturating margin
        for (int i = 0; i < N; i++) cyc(1'b1, (i == 0) ? 32767 : -32768);
        chk("sat_class", class_id, 0);
        chk("sat_max", max_score, 32767);
        chk("sat_margin", margin, 16'hFFFF);
        idle(1);

        // Restart mid-frame with a same-cycle score
        ov0 = n_ov;
        for (int i = 0; i < 4; i++) cyc(1'b1, 200);
        cyc(1'b1, 50, 1'b1);
        for (int i = 0; i < N - 1; i++) cyc(1'b1, i * 3);
        chk("st_ovalid", ovalid, 1);
        chk("st_class", class_id, 0);
        chk("st_max", max_score, 50);
        chk("st_margin", margin, 26);
        idle(3);
        chk("st_pulses", n_ov - ov0, 1);

        // Back-to-back frames, gapped ivalid in frame A
        ov0 = n_ov;
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, (i == 2) ? 500 : i);
            if (i % 2 == 1 && i != N - 1) cyc(1'b0, 0);
        end
        chk("b2b_a_ovalid", ovalid, 1);
        chk("b2b_a_busy", busy, 0);
        chk("b2b_a_class", class_id, 2);
        for (int i = 0; i < N; i++) cyc(1'b1, (i == 8) ? 700 : -i);
        chk("b2b_b_class", class_id, 8);
        chk("b2b_b_max", max_score, 700);
        chk("b2b_b_margin", margin, 700);
        idle(1);
        chk("b2b_pulses", n_ov - ov0, 2);

        // Reset mid-frame
        ov0 = n_ov;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1000 + i);
        rstn = 1'b0;
        cyc(1'b0, 0);
        rstn = 1'b1;
        chk("mr_class", class_id, 0);
        chk("mr_max", max_score, 0);
        chk("mr_margin", margin, 0);
        chk("mr_busy", busy, 0);
        idle(2);
        chk("mr_no_ovalid", n_ov - ov0, 0);
        for (int i = 0; i < N; i++) cyc(1'b1, (i == 6) ? 42 : i);
        chk("mr_class2", class_id, 6);
        chk("mr_max2", max_score, 42);
        chk("mr_margin2", margin, 33);
        idle(1);

`ifdef FC_ARGMAX_SCORE_BUF_EN
        // Score buffer read-back holds across the next frame
        for (int i = 0; i < N; i++) cyc(1'b1, 9 - i);
        rd_addr = 4'd4;
        cyc(1'b0, 0);
        chk("buf_rd", rd_data, 5);
        for (int i = 0; i < N - 1; i++) begin
            cyc(1'b1, 300 + i);
            chk("buf_hold", rd_data, 5);
        end
        cyc(1'b1, 1);
        idle(1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                case ($urandom_range(0, 3))
                    0: d = -32768;
                    1: d = 32767;
                    2: d = 0;
                    default: d = -1;
                endcase
            end else if (r == 1) begin
                d = int'($urandom_range(0, 6)) - 3;
            end else begin
                d = int'($urandom_range(0, 65535)) - 32768;
            end
`ifdef FC_ARGMAX_SCORE_BUF_EN
            rd_addr = 4'($urandom_range(0, 15));
`endif
            rstn = ($urandom_range(0, 400) != 0);
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 80) == 0);
        end
        rstn = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
